mem_burst_reader: RTL
=====================

MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 Parameters (name, default, meaning): WORD_SIZE, 1, read-data width in bytes; ADDR_SIZE, 32, address width; LEN_SIZE, 16, burst word-count width; ADDR_STRIDE, 1, address increment per word; FIFO_DEPTH, 4, output buffer entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  burst request, single-cycle qualifier.
REQ-005 start_addr  in  ADDR_SIZE  first word address; sampled with start.
REQ-006 word_count  in  LEN_SIZE  words in burst; sampled with start.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse on burst completion.
REQ-009 read_en  out  1  memory read request, one word per asserted cycle.
REQ-010 addr  out  ADDR_SIZE  memory read address, valid when read_en high.
REQ-011 read_data  in  WORD_SIZE*8  memory read data, valid when data_ready high.
REQ-012 data_ready  in  1  memory response strobe, one per issued read, in issue order.
REQ-013 out_valid / out_ready / out_data  out / in / out  1 / 1 / WORD_SIZE*8  output stream handshake.
REQ-014 proto_err  out  1  sticky: data_ready seen with zero reads outstanding.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN; start accepted only in IDLE, ignored otherwise.
REQ-016 IDLE->ISSUE on start with word_count>0; IDLE stays IDLE with done pulsed next cycle on start with word_count==0, no read_en.
REQ-017 In ISSUE, read_en asserted in a cycle iff remaining>0 and fifo_count+outstanding<FIFO_DEPTH (credit rule); read data never dropped.
REQ-018 addr = start_addr + k*ADDR_STRIDE for k-th issued word, modulo 2^ADDR_SIZE (wrap permitted, no error).
REQ-019 ISSUE->DRAIN in the cycle after the last read_en; DRAIN->IDLE when outstanding==0 and FIFO empty, done pulsed in that transition cycle's following clock edge, busy deasserted with done.
REQ-020 Responder latency unconstrained (>=1 cycle); outstanding counter increments on read_en, decrements on data_ready, both in same cycle leave it unchanged.
REQ-021 read_data written to FIFO on data_ready; FIFO write and read in same cycle legal at any fill level, including full-with-read and empty-with-write (no bypass; min latency data_ready->out_valid one cycle).
REQ-022 out_data stable while out_valid high and out_ready low; word popped when out_valid&&out_ready.
REQ-023 Output order equals issue order; exactly word_count words per burst.
REQ-024 data_ready with outstanding==0: word discarded, proto_err set until rst.
REQ-025 Counters sized: remaining LEN_SIZE bits, outstanding and fifo_count $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 rst has priority over all inputs; mid-burst rst aborts burst, flushes FIFO, clears counters.
REQ-027 Reset values: state IDLE, busy 0, done 0, read_en 0, addr 0, out_valid 0, out_data 0, proto_err 0.
REQ-028 Responses arriving after rst deassertion for pre-reset reads set proto_err (bench responsibility to avoid).

Structure
REQ-029 FSM state enum and burst-descriptor struct (addr, count) in shared package MemPkg.
REQ-030 Output buffer is sub-module sync_fifo (parameters WIDTH, DEPTH; count output), instanced once.

Verification
REQ-031 Bench pairs the block with the existing simulation RAM model loaded so mem[i]=i+0x10.
REQ-032 start_addr=4, word_count=3, out_ready=1 -> addr 4,5,6 on consecutive cycles; out_data 0x14,0x15,0x16; one done pulse; busy low after.
REQ-033 word_count=0 -> no read_en, done one cycle after start, busy stays 0.
REQ-034 word_count=10, out_ready=0 for 20 cycles -> exactly 4 read_en then stall; release -> all 10 words in order, no loss.
REQ-035 start_addr=0xFFFF_FFFE, word_count=4 -> addr FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-036 rst asserted after 2 of 8 words delivered -> outputs at reset values next cycle; new burst then completes normally; spurious data_ready while idle -> proto_err=1.

Source files
------------

// File: rtl/mem_burst_reader_pkg.sv
// Shared types for the burst reader: FSM state encoding and the burst
// descriptor latched when a request is accepted.
package MemPkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Descriptor fields are sized for the widest supported configuration
  // (ADDR_SIZE <= 64, LEN_SIZE <= 32); the reader narrows them on load.
  localparam int DESC_ADDR_W = 64;
  localparam int DESC_LEN_W  = 32;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0]  count;
  } burst_desc_t;

  function automatic burst_desc_t make_desc(input logic [DESC_ADDR_W-1:0] a,
                                            input logic [DESC_LEN_W-1:0]  c);
    burst_desc_t d;
    d.addr  = a;
    d.count = c;
    return d;
  endfunction

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Synchronous FIFO buffering read responses toward the output stream.
// Simultaneous push/pop is legal at any fill level; no write-to-read bypass.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  // Head word shown only while valid so the output reads zero when empty.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a full FIFO may still accept a push.
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst memory reader: issues word_count reads from start_addr onward,
// limited by credit so every response has a guaranteed FIFO slot, and
// streams responses out in issue order.
module mem_burst_reader
  import MemPkg::*;
#(
  parameter int WORD_SIZE   = 1,
  parameter int ADDR_SIZE   = 32,
  parameter int LEN_SIZE    = 16,
  parameter int ADDR_STRIDE = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_SIZE-1:0]   start_addr,
  input  logic [LEN_SIZE-1:0]    word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   read_en,
  output logic [ADDR_SIZE-1:0]   addr,
  input  logic [WORD_SIZE*8-1:0] read_data,
  input  logic                   data_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE*8-1:0] out_data,
  output logic                   proto_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [LEN_SIZE-1:0]   rem_q, rem_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;

  burst_desc_t           req_desc;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty, fifo_wr, credit_ok, issue;

  assign req_desc = make_desc(DESC_ADDR_W'(start_addr), DESC_LEN_W'(word_count));

  // Words in flight plus words buffered must fit the FIFO before a new read.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state_q == ISSUE) && (rem_q != '0) && credit_ok;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign fifo_wr   = data_ready && (outst_q != '0);

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign read_en   = issue;
  assign addr      = addr_q;
  assign out_valid = !fifo_empty;
  assign proto_err = perr_q;

  // Next-state, address/remaining bookkeeping and completion pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    perr_d  = perr_q | (data_ready && (outst_q == '0));
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d = ISSUE;
            addr_d  = ADDR_SIZE'(req_desc.addr);
            rem_d   = LEN_SIZE'(req_desc.count);
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_SIZE'(ADDR_STRIDE);
          rem_d  = rem_q - LEN_SIZE'(1);
          if (rem_q == LEN_SIZE'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-read counter: issue adds, accepted response removes.
  always_comb begin
    outst_d = outst_q;
    case ({issue, fifo_wr})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // State registers; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_SIZE*8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (read_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
